// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, op and state
// encodings, and operand sign helpers.
package mdu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned ITERATIONS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

  // Magnitude of a two's complement value when treated as signed, raw value otherwise.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic signed_op);
    return (signed_op && x[XLEN-1]) ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Execute-stage connection of the multiply/divide unit: operands, MTHI/MTLO, status and HI/LO.
interface mdu_iterative_if;
  import mdu_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            wr_hi;
  logic            wr_lo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, flush, wr_hi, wr_lo, wdata,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
    output busy, done, stall, hi, lo
  );

endinterface

// File: rtl/mdu_step.sv
// One iteration of either shift-add multiply or restoring shift-subtract divide.
// acc is the high half (product high / partial remainder), quo the low half.
module mdu_step
  import mdu_pkg::*;
(
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          fits;

  always_comb begin
    sum      = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
    shifted  = {acc, quo[XLEN-1]};
    fits     = (shifted >= {1'b0, opnd});
    acc_next = sum[XLEN:1];
    quo_next = {sum[0], quo[XLEN-1:1]};
    // Remainder stays below the divisor, so the upper bit of the difference is always zero.
    if (div_mode) begin
      acc_next = fits ? XLEN'(shifted - {1'b0, opnd}) : shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; fixed 33-cycle latency
// from acceptance to the done pulse, stalling the front of the pipe meanwhile.
module mdu_iterative
  import mdu_pkg::*;
(
  input logic               clk,
  input logic               reset,
  mdu_iterative_if.slave    bus
);

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  opnd;
  logic             sign_q;
  logic             sign_r;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic             done_q;

  logic [XLEN-1:0]   acc_next;
  logic [XLEN-1:0]   quo_next;
  logic [2*XLEN-1:0] product_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic              accept_signed;
  logic              accept_div;

  mdu_step u_step (
    .div_mode (op_is_div(op_q)),
    .acc      (acc),
    .quo      (quo),
    .opnd     (opnd),
    .acc_next (acc_next),
    .quo_next (quo_next)
  );

  // Sign correction; a zero divisor forces an all-ones quotient and returns the dividend as remainder.
  always_comb begin
    product_fix   = sign_q ? -{acc, quo} : {acc, quo};
    quo_fix       = sign_q ? -quo : quo;
    rem_fix       = sign_r ? -acc : acc;
    if (opnd == '0) quo_fix = '1;
    accept_signed = op_is_signed(op_e'(bus.op));
    accept_div    = op_is_div(op_e'(bus.op));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= OP_MULT;
      count  <= '0;
      acc    <= '0;
      quo    <= '0;
      opnd   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.wr_hi && !done_q) hi_q <= bus.wdata;
          if (bus.wr_lo && !done_q) lo_q <= bus.wdata;
          if (bus.start && !done_q && !bus.flush) begin
            state  <= S_CALC;
            op_q   <= op_e'(bus.op);
            count  <= '0;
            acc    <= '0;
            quo    <= magnitude(accept_div ? bus.a : bus.b, accept_signed);
            opnd   <= magnitude(accept_div ? bus.b : bus.a, accept_signed);
            sign_q <= accept_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            sign_r <= accept_signed & bus.a[XLEN-1];
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state <= S_IDLE;
            count <= '0;
          end else begin
            acc <= acc_next;
            quo <= quo_next;
            if (count == CNT_W'(ITERATIONS - 1)) begin
              state <= S_FIX;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          count <= '0;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (op_is_div(op_q)) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= product_fix[2*XLEN-1:XLEN];
              lo_q <= product_fix[XLEN-1:0];
            end
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_q;
  assign bus.stall = (state != S_IDLE) | (bus.start & ~done_q);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mdu_iterative;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mdu_iterative_if bus();

  mdu_iterative dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result of one operation, computed directly from signed/unsigned arithmetic.
  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, b,
                           output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'b00: begin p = 64'(longint'(sa) * longint'(sb)); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 32'd0; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
  endtask

  // Launches one op and waits (bounded) for done; reports results and the cycle after done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, b, input bit hold,
                        output logic [31:0] got_hi, output logic [31:0] got_lo,
                        output int lat, output int stall_cnt,
                        output logic stall_done, output logic busy_next, output logic done_next);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    lat = 0; stall_cnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.stall === 1'b1) stall_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    got_hi = bus.hi; got_lo = bus.lo; stall_done = bus.stall;
    if (!hold) bus.start = 1'b0;
    @(posedge clk); #1;
    busy_next = bus.busy; done_next = bus.done;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, 32'd0); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, 32'd0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    logic [31:0] h, l; int lat, sc; logic sd, bn, dn;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, h, l, lat, sc, sd, bn, dn);
    checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=%h", h, 32'hFFFF_FFFE); end
    checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=%h", l, 32'h1); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got=%0d exp=33", lat); end
    checks++; if (sc !== 33) begin errors++; $display("FAIL multu_stall_cycles got=%0d exp=33", sc); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL multu_stall_in_done got=%b exp=0", sd); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL multu_done_width got=%b exp=0", dn); end
  endtask

  task automatic test_mult_mtlo();
    logic [31:0] h, l; int lat, sc; logic sd, bn, dn;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, h, l, lat, sc, sd, bn, dn);
    checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=%h", h, 32'hFFFF_FFFF); end
    checks++; if (l !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got=%h exp=%h", l, 32'hFFFF_FFEB); end
    bus.wdata = 32'h1234; bus.wr_lo = 1'b1;
    @(posedge clk); #1;
    bus.wr_lo = 1'b0;
    checks++; if (bus.lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo got=%h exp=%h", bus.lo, 32'h1234); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mtlo_hi got=%h exp=%h", bus.hi, 32'hFFFF_FFFF); end
  endtask

  task automatic test_divide();
    logic [31:0] h, l; int lat, sc; logic sd, bn, dn;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, h, l, lat, sc, sd, bn, dn);
    checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got=%h exp=%h", l, 32'hFFFF_FFFD); end
    checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got=%h exp=%h", h, 32'hFFFF_FFFF); end
    run_op(2'b11, 32'd7, 32'd0, 1'b1, h, l, lat, sc, sd, bn, dn);
    checks++; if (l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo got=%h exp=%h", l, 32'hFFFF_FFFF); end
    checks++; if (h !== 32'd7) begin errors++; $display("FAIL divu_zero_hi got=%h exp=%h", h, 32'd7); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_zero_latency got=%0d exp=33", lat); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, h, l, lat, sc, sd, bn, dn);
    checks++; if (l !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=%h", l, 32'h8000_0000); end
    checks++; if (h !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got=%h exp=%h", h, 32'd0); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_ovf_latency got=%0d exp=33", lat); end
  endtask

  task automatic preload(input logic [31:0] hv, input logic [31:0] lv);
    bus.wdata = hv; bus.wr_hi = 1'b1;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0; bus.wdata = lv; bus.wr_lo = 1'b1;
    @(posedge clk); #1;
    bus.wr_lo = 1'b0;
  endtask

  // Flush sampled at edge fe (10 = mid-CALC, 33 = FIX cycle); HI/LO must keep preloaded values.
  task automatic test_flush(input int fe);
    int saw_done;
    preload(32'hAA, 32'hBB);
    bus.op = 2'b01; bus.a = $urandom | 32'h1; bus.b = $urandom | 32'h1; bus.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < fe; i++) begin
      bus.wr_hi = 1'b1; bus.wdata = 32'h5555;
      @(posedge clk); #1;
    end
    bus.wr_hi = 1'b0;
    bus.flush = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush%0d_busy got=%b exp=0", fe, bus.busy); end
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done === 1'b1) saw_done++;
      @(posedge clk); #1;
    end
    checks++; if (saw_done !== 0) begin errors++; $display("FAIL flush%0d_done got=%0d exp=0", fe, saw_done); end
    checks++; if (bus.hi !== 32'hAA) begin errors++; $display("FAIL flush%0d_hi got=%h exp=%h", fe, bus.hi, 32'hAA); end
    checks++; if (bus.lo !== 32'hBB) begin errors++; $display("FAIL flush%0d_lo got=%h exp=%h", fe, bus.lo, 32'hBB); end
  endtask

  task automatic test_reset_mid_op();
    preload(32'hAA, 32'hBB);
    bus.op = 2'b01; bus.a = 32'h1234_5678; bus.b = 32'h9; bus.start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL async_reset_hi got=%h exp=%h", bus.hi, 32'd0); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL async_reset_lo got=%h exp=%h", bus.lo, 32'd0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_held_start();
    logic [31:0] h, l; int lat, sc; logic sd, bn, dn;
    run_op(2'b01, 32'd6, 32'd9, 1'b1, h, l, lat, sc, sd, bn, dn);
    checks++; if (l !== 32'd54) begin errors++; $display("FAIL held_lo got=%h exp=%h", l, 32'd54); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL held_stall_in_done got=%b exp=0", sd); end
    checks++; if (bn !== 1'b0) begin errors++; $display("FAIL held_no_relaunch got=%b exp=0", bn); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL held_done_width got=%b exp=0", dn); end
  endtask

  task automatic test_random(input int n);
    logic [31:0] h, l, eh, el, a, b; logic [1:0] op; int lat, sc, sel; logic sd, bn, dn;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 20)) ^ {32{b[31]}};
      ref_model(op, a, b, eh, el);
      run_op(op, a, b, 1'b0, h, l, lat, sc, sd, bn, dn);
      checks++;
      if (h !== eh || l !== el || lat !== 33) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h got hi=%h lo=%h lat=%0d exp hi=%h lo=%h lat=33",
                 op, a, b, h, l, lat, eh, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_mtlo();
    test_divide();
    test_flush(10);
    test_flush(33);
    test_reset_mid_op();
    test_held_start();
    test_random(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
